// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file for the decode stage.
// Combinational read ports bypass same-cycle writes. A pending-bit
// scoreboard tracks destinations reserved by long-latency operations
// so that decode can stall on operands that are not yet available.
module grf_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     any_pend
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [ADDR_W:0]   r_pendCnt;

  logic w_w0Apply;
  logic w_w1Apply;
  logic w_issApply;
  logic w_cntInc;
  logic w_cntDec;

  // Register 0 is read-only zero when ZERO_REG is set.
  function automatic logic isProtected(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Enables are gated by reset_n so that nothing, not even the read
  // bypass, reflects a write request while reset is held.
  assign w_w0Apply  = reset_n && w0_en  && !isProtected(w0_addr);
  assign w_w1Apply  = reset_n && w1_en  && !isProtected(w1_addr);
  assign w_issApply = reset_n && iss_en && !isProtected(iss_addr);

  // The counter moves only when a pending bit actually changes state.
  // A same-address issue and completion keeps the bit set, so it is
  // not a decrement.
  assign w_cntInc = w_issApply && !r_pending[iss_addr];
  assign w_cntDec = w_w1Apply && r_pending[w1_addr] &&
                    !(w_issApply && (iss_addr == w1_addr));

  // Register array: W0 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_w1Apply) r_mem[w1_addr] <= w1_data;
      if (w_w0Apply) r_mem[w0_addr] <= w0_data;
    end
  end

  // Pending vector: completion clears, then a new issue re-sets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      if (w_w1Apply)  r_pending[w1_addr]  <= 1'b0;
      if (w_issApply) r_pending[iss_addr] <= 1'b1;
    end
  end

  // Pending counter tracks the population of the pending vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pendCnt <= '0;
    end else begin
      case ({w_cntInc, w_cntDec})
        2'b10:   r_pendCnt <= r_pendCnt + CNT_ONE;
        2'b01:   r_pendCnt <= r_pendCnt - CNT_ONE;
        default: r_pendCnt <= r_pendCnt;
      endcase
    end
  end

  assign pend_cnt = r_pendCnt;
  assign any_pend = (r_pendCnt != '0);

  // Per-port read: zero register, then W0 bypass, W1 bypass, stored value.
  // A completing W1 releases the stall in the same cycle.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_prot;
    logic              w_hitW0;
    logic              w_hitW1;

    assign w_addr  = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_prot  = isProtected(w_addr);
    assign w_hitW0 = w_w0Apply && (w0_addr == w_addr);
    assign w_hitW1 = w_w1Apply && (w1_addr == w_addr);

    assign rd_data[k*DATA_W +: DATA_W] = w_prot  ? '0      :
                                         w_hitW0 ? w0_data :
                                         w_hitW1 ? w1_data :
                                                   r_mem[w_addr];
    assign rd_busy[k] = !w_prot && r_pending[w_addr] && !w_hitW1;
  end

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed self-checking bench for grf_mp.
// Three instances: default parameters, ZERO_REG=0 sharing the same
// stimulus, and a small ADDR_W=3 file used for the fill scenario.
module tb_grf_mp;

  logic        clk;
  logic        reset_n;

  // Main and non-zero-register instances share these inputs
  logic [9:0]  rdAddr;
  logic        w0En, w1En, issEn;
  logic [4:0]  w0Addr, w1Addr, issAddr;
  logic [31:0] w0Data, w1Data;

  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic [5:0]  pendCnt;
  logic        anyPend;

  logic [63:0] rdDataNz;
  logic [1:0]  rdBusyNz;
  logic [5:0]  pendCntNz;
  logic        anyPendNz;

  // Small instance
  logic [2:0]  sRdAddr;
  logic        sW0En, sW1En, sIssEn;
  logic [2:0]  sW0Addr, sW1Addr, sIssAddr;
  logic [7:0]  sW0Data, sW1Data;
  logic [7:0]  sRdData;
  logic [0:0]  sRdBusy;
  logic [3:0]  sPendCnt;
  logic        sAnyPend;

  int testsRun;
  int testsFailed;

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_main (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .w0_en(w0En), .w0_addr(w0Addr), .w0_data(w0Data),
    .w1_en(w1En), .w1_addr(w1Addr), .w1_data(w1Data),
    .iss_en(issEn), .iss_addr(issAddr),
    .pend_cnt(pendCnt), .any_pend(anyPend)
  );

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_nz (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rdAddr), .rd_data(rdDataNz), .rd_busy(rdBusyNz),
    .w0_en(w0En), .w0_addr(w0Addr), .w0_data(w0Data),
    .w1_en(w1En), .w1_addr(w1Addr), .w1_data(w1Data),
    .iss_en(issEn), .iss_addr(issAddr),
    .pend_cnt(pendCntNz), .any_pend(anyPendNz)
  );

  grf_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(1), .ZERO_REG(1)) u_small (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(sRdAddr), .rd_data(sRdData), .rd_busy(sRdBusy),
    .w0_en(sW0En), .w0_addr(sW0Addr), .w0_data(sW0Data),
    .w1_en(sW1En), .w1_addr(sW1Addr), .w1_data(sW1Data),
    .iss_en(sIssEn), .iss_addr(sIssAddr),
    .pend_cnt(sPendCnt), .any_pend(sAnyPend)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the shared main-port inputs for the next cycle
  task automatic applyStimulus(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic ei, input logic [4:0] ai);
    w0En = e0; w0Addr = a0; w0Data = d0;
    w1En = e1; w1Addr = a1; w1Data = d1;
    issEn = ei; issAddr = ai;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] port(input logic [63:0] d, input int k);
    return d[k*32 +: 32];
  endfunction

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset_n = 1'b0;
    rdAddr  = {5'd0, 5'd5};
    idle();
    sRdAddr = 3'd0;
    sW0En = 1'b0; sW0Addr = 3'd0; sW0Data = 8'h0;
    sW1En = 1'b0; sW1Addr = 3'd0; sW1Data = 8'h0;
    sIssEn = 1'b0; sIssAddr = 3'd0;

    // Reset state
    #2;
    checkOutput("reset_rd0", port(rdData, 0), 32'h0);
    checkOutput("reset_rd1", port(rdData, 1), 32'h0);
    checkOutput("reset_busy", rdBusy, 2'b00);
    checkOutput("reset_cnt", pendCnt, 6'd0);
    checkOutput("reset_any", anyPend, 1'b0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    #1;

    // Zero register: W0 and issue to r0
    rdAddr = {5'd0, 5'd0};
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    #1;
    checkOutput("zero_rd_bypass", port(rdData, 0), 32'h0);
    checkOutput("zero_busy_now", rdBusy[0], 1'b0);
    nextCycle();
    idle();
    #1;
    checkOutput("zero_rd_next", port(rdData, 0), 32'h0);
    checkOutput("zero_busy_next", rdBusy[0], 1'b0);
    checkOutput("zero_cnt", pendCnt, 6'd0);
    checkOutput("nz_rd_next", port(rdDataNz, 0), 32'h1234);
    checkOutput("nz_cnt", pendCntNz, 6'd1);
    checkOutput("nz_busy", rdBusyNz[0], 1'b1);

    // Bypass priority: W0 beats W1 at the same address
    rdAddr = {5'd3, 5'd3};
    applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555, 1'b0, 5'd0);
    #1;
    checkOutput("prio_rd0_now", port(rdData, 0), 32'hAAAA);
    checkOutput("prio_rd1_now", port(rdData, 1), 32'hAAAA);
    nextCycle();
    idle();
    #1;
    checkOutput("prio_rd0_stored", port(rdData, 0), 32'hAAAA);

    // W1-only bypass and store
    rdAddr = {5'd4, 5'd3};
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h5555, 1'b0, 5'd0);
    #1;
    checkOutput("w1_rd1_now", port(rdData, 1), 32'h5555);
    nextCycle();
    idle();
    #1;
    checkOutput("w1_rd1_stored", port(rdData, 1), 32'h5555);
    checkOutput("w1_nonpend_cnt", pendCnt, 6'd0);

    // Scoreboard lifecycle on r9
    rdAddr = {5'd10, 5'd9};
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    #1;
    checkOutput("life_busy_c0", rdBusy[0], 1'b0);
    nextCycle();
    idle();
    #1;
    checkOutput("life_busy_c1", rdBusy[0], 1'b1);
    checkOutput("life_cnt_c1", pendCnt, 6'd1);
    checkOutput("life_any_c1", anyPend, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("life_busy_c3", rdBusy[0], 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
    #1;
    checkOutput("life_busy_c4", rdBusy[0], 1'b0);
    checkOutput("life_rd_c4", port(rdData, 0), 32'h77);
    checkOutput("life_cnt_c4", pendCnt, 6'd1);
    nextCycle();
    idle();
    #1;
    checkOutput("life_cnt_c5", pendCnt, 6'd0);
    checkOutput("life_any_c5", anyPend, 1'b0);
    checkOutput("life_rd_c5", port(rdData, 0), 32'h77);

    // Same-address issue and completion
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    nextCycle();
    idle();
    #1;
    checkOutput("same_cnt_pre", pendCnt, 6'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h88, 1'b1, 5'd9);
    #1;
    checkOutput("same_busy_now", rdBusy[0], 1'b0);
    checkOutput("same_rd_now", port(rdData, 0), 32'h88);
    nextCycle();
    idle();
    #1;
    checkOutput("same_busy_next", rdBusy[0], 1'b1);
    checkOutput("same_cnt_next", pendCnt, 6'd1);

    // Different-address issue and completion
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10);
    nextCycle();
    idle();
    #1;
    checkOutput("diff_cnt", pendCnt, 6'd1);
    checkOutput("diff_busy", rdBusy, 2'b10);
    checkOutput("diff_rd0", port(rdData, 0), 32'h99);

    // Stray completion to a non-pending register
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hBB, 1'b0, 5'd0);
    nextCycle();
    idle();
    #1;
    checkOutput("stray_cnt", pendCnt, 6'd1);

    // Reset mid-operation
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    nextCycle();
    idle();
    rdAddr = {5'd7, 5'd5};
    #1;
    checkOutput("mid_rd0_pre", port(rdData, 0), 32'hDEADBEEF);
    checkOutput("mid_busy1_pre", rdBusy[1], 1'b1);
    checkOutput("mid_cnt_pre", pendCnt, 6'd2);
    reset_n = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h1111, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    #1;
    checkOutput("mid_rd0_rst", port(rdData, 0), 32'h0);
    checkOutput("mid_busy_rst", rdBusy, 2'b00);
    checkOutput("mid_cnt_rst", pendCnt, 6'd0);
    checkOutput("mid_any_rst", anyPend, 1'b0);
    nextCycle();
    checkOutput("mid_rd0_rst_edge", port(rdData, 0), 32'h0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("mid_rd0_after", port(rdData, 0), 32'h0);
    checkOutput("mid_busy1_after", rdBusy[1], 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h42, 1'b0, 5'd0);
    #1;
    checkOutput("mid_w1_rd1_now", port(rdData, 1), 32'h42);
    nextCycle();
    idle();
    #1;
    checkOutput("mid_w1_rd1_stored", port(rdData, 1), 32'h42);
    checkOutput("mid_w1_cnt", pendCnt, 6'd0);

    // Fill the small file: r1..r7 pending
    for (int i = 1; i < 8; i++) begin
      sIssEn = 1'b1;
      sIssAddr = 3'(i);
      nextCycle();
    end
    sIssEn = 1'b0;
    #1;
    checkOutput("fill_cnt", sPendCnt, 4'd7);
    checkOutput("fill_any", sAnyPend, 1'b1);
    sIssEn = 1'b1; sIssAddr = 3'd0;
    nextCycle();
    sIssEn = 1'b0;
    #1;
    checkOutput("fill_r0_iss_cnt", sPendCnt, 4'd7);
    sIssEn = 1'b1; sIssAddr = 3'd4;
    nextCycle();
    sIssEn = 1'b0;
    sRdAddr = 3'd4;
    #1;
    checkOutput("fill_reiss_cnt", sPendCnt, 4'd7);
    checkOutput("fill_r4_busy", sRdBusy, 1'b1);
    sRdAddr = 3'd2;
    sW1En = 1'b1; sW1Addr = 3'd2; sW1Data = 8'h3C;
    #1;
    checkOutput("fill_r2_busy_now", sRdBusy, 1'b0);
    checkOutput("fill_r2_rd_now", sRdData, 8'h3C);
    nextCycle();
    sW1En = 1'b0;
    #1;
    checkOutput("fill_cnt_done", sPendCnt, 4'd6);
    sW1En = 1'b1; sW1Addr = 3'd2; sW1Data = 8'h5A;
    nextCycle();
    sW1En = 1'b0;
    #1;
    checkOutput("fill_stray_cnt", sPendCnt, 4'd6);
    checkOutput("fill_stray_rd", sRdData, 8'h5A);
    sW1En = 1'b1; sW1Addr = 3'd0; sW1Data = 8'hFF;
    nextCycle();
    sW1En = 1'b0;
    sRdAddr = 3'd0;
    #1;
    checkOutput("fill_r0_w1_cnt", sPendCnt, 4'd6);
    checkOutput("fill_r0_rd", sRdData, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised multi-port general register file with a long-latency write scoreboard. It sits in the decode stage of the pipelined CPU. It provides `NUM_RD` combinational read ports with write-through bypass, and two write ports: W0 for the pipeline writeback and W1 for the multicycle unit (mult/div, loads from slow memory). Per-register pending bits let decode stall on operands that a long-latency operation has not yet produced.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth = 2^ADDR_W.
- `NUM_RD`, 2: number of read ports (1..4).
- `ZERO_REG`, 1: 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W  read data, combinational, packed the same way.
- `rd_busy`  out  NUM_RD  port k operand still pending (stall request).
- `w0_en`, `w0_addr`, `w0_data`  in  1 / ADDR_W / DATA_W  pipeline writeback port.
- `w1_en`, `w1_addr`, `w1_data`  in  1 / ADDR_W / DATA_W  long-latency completion port; also clears the pending bit.
- `iss_en`, `iss_addr`  in  1 / ADDR_W  long-latency issue; reserves the destination register.
- `pend_cnt`  out  ADDR_W+1  number of registers currently pending (registered).
- `any_pend`  out  1  `pend_cnt != 0`.

## Operation
- State: register array (2^ADDR_W x DATA_W), pending vector (2^ADDR_W), `pend_cnt`.
- **Writes, at the rising edge:**
  - Write applies if `wX_en` is set, unless `ZERO_REG=1` and `wX_addr == 0` (protected address).
  - W0 and W1 to the same address in the same cycle: W0 data is stored.
- **Read data**, per port, in priority order:
  - Protected address gives 0.
  - Else, if W0 applies to the same address, `w0_data`.
  - Else, if W1 applies to the same address, `w1_data`.
  - Else, the stored value.
- **Pending bits:**
  - `iss_en` to a non-protected address sets the bit.
  - An applied W1 clears the bit for its address.
  - Issue and W1 to the same address in the same cycle: the bit stays set (the new reservation wins).
  - W0 never touches pending bits.
  - W1 to a non-pending address performs the write; the bit stays clear.
- **rd_busy[k]** = `pending[addr_k]` AND NOT (W1 applies to `addr_k` this cycle). Always 0 for a protected address.
- **pend_cnt** next value:
  - +1 when a set lands on a non-pending bit.
  - −1 when a clear lands on a pending bit with no same-address issue.
  - Both events in one cycle on different addresses: net 0.
  - Never wraps: the maximum is 2^ADDR_W (or 2^ADDR_W−1 with `ZERO_REG`), reachable only by issue.

## Timing
- **Reset:** `reset_n` low immediately and asynchronously clears all registers, all pending bits and `pend_cnt`. Resulting outputs: `rd_data` = 0 on all ports, `rd_busy` = 0, `pend_cnt` = 0, `any_pend` = 0.
- **Writes during reset:** `w0_en`, `w1_en` and `iss_en` are ignored while `reset_n` is low. A deassertion edge coinciding with the clock edge takes no update.
- **Reset mid-operation:** all pending reservations are discarded; a later W1 to a discarded address writes data and leaves `pend_cnt` unchanged.
- **Read latency:** 0 cycles (combinational). A write is visible on `rd_data` in the same cycle through the bypass, and from the stored array from the next cycle.
- **Issue to busy latency:** `rd_busy` rises the cycle after the `iss_en` edge (not in the issue cycle itself).
- **Completion to busy latency:** `rd_busy` falls combinationally in the W1 cycle, with `rd_data` = `w1_data`.
- **Counter update:** `pend_cnt` updates at the edge that updates the pending vector.

## Test plan
- **Reset:** assert `reset_n`=0 mid-run after writing 0xDEADBEEF to r5 and issuing r7 -> same cycle `rd_data`=0 for r5, `pend_cnt`=0; after release, reading r7 gives `rd_busy`=0.
- **Zero register:** with `ZERO_REG=1`, W0 writes 0x1234 to r0 and issue targets r0 -> read r0 = 0, `rd_busy`=0, `pend_cnt` unchanged. With `ZERO_REG=0` the same stimulus gives a read of 0x1234 next cycle and `pend_cnt`=1.
- **Bypass priority:** W0 (r3, 0xAAAA) and W1 (r3, 0x5555) in the same cycle -> port 0 reading r3 gives 0xAAAA that cycle and 0xAAAA after the edge.
- **Scoreboard lifecycle:**
  - Issue r9 at cycle 0 -> `rd_busy`=1 from cycle 1, `pend_cnt`=1.
  - W1 (r9, 0x77) at cycle 4 -> `rd_busy`=0 and `rd_data`=0x77 in cycle 4; `pend_cnt`=0 at cycle 5.
- **Simultaneous issue and complete:**
  - Same address: pending r9, issue r9 and W1 r9 together -> r9 still busy next cycle, `pend_cnt`=1.
  - Different addresses: issue r10 and W1 r9 together -> `pend_cnt` stays 1, r10 busy.
- **Fill:** with `ADDR_W=3` and `ZERO_REG=1`, issue r1..r7 -> `pend_cnt`=7; re-issue r4 -> `pend_cnt` stays 7; a stray W1 to a non-pending address -> no underflow.
